// File: rtl/pong_ball_engine.sv
// -----------------------------------------------------------------------------
// pong_ball_engine
//
// Ball, paddle, scoring and game-flow engine for the LED-bar ping-pong game.
// A one-hot ball walks across a WIDTH-bit LED bar. A programmable prescaler
// sets the step rate. The engine handles paddle hits with per-rally lockout,
// misses and scoring, and a rally speed-up. It also runs the point flash and
// the game-over hold.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   serve_l    in   left serve request (level, acted on in IDLE only)
//   serve_r    in   right serve request (level, acted on in IDLE only)
//   hit_l      in   left paddle button, synchronised level
//   hit_r      in   right paddle button, synchronised level
//   leds       out  ball / flash display, leds[WIDTH-1] = left end
//   score_l    out  left player score
//   score_r    out  right player score
//   game_over  out  high once a player reaches WIN_SCORE
//   winner     out  0 = left, 1 = right; valid while game_over = 1
// -----------------------------------------------------------------------------
module pong_ball_engine #(
  parameter int WIDTH            = 18,
  parameter int DIV_W            = 26,
  parameter int BASE_DIV         = 12500000,
  parameter int MIN_DIV          = 1562500,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SCORE_W          = 4,
  parameter int WIN_SCORE        = 7,
  parameter int FLASH_TICKS      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serve_l,
  input  logic               serve_r,
  input  logic               hit_l,
  input  logic               hit_r,
  output logic [WIDTH-1:0]   leds,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner
);

  localparam int HC_W = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int FL_W = $clog2(FLASH_TICKS + 1);

  localparam logic [DIV_W-1:0]   BASE_V    = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0]   MIN_V     = DIV_W'(MIN_DIV);
  localparam logic [WIDTH-1:0]   LEFT_END  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   RIGHT_END = WIDTH'(1);
  localparam logic [WIDTH-1:0]   ALL_ON    = {WIDTH{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [HC_W-1:0]    HC_LAST   = HC_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [FL_W-1:0]    FL_LAST   = FL_W'(FLASH_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_L,
    MOVE_R,
    POINT,
    OVER
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cur_div;
  // Hits since serve, kept modulo HITS_PER_SPEEDUP: a wrap to zero is exactly
  // the point where the running total becomes a multiple of the interval.
  logic [HC_W-1:0]  hit_cnt;
  logic [FL_W-1:0]  flash_cnt;
  logic             lockout_l;
  logic             lockout_r;
  logic             hit_l_q;
  logic             hit_r_q;
  logic             scorer;

  logic             press_l;
  logic             press_r;
  logic             tick;
  logic             hit_wrap;
  logic [DIV_W-1:0] half_div;
  logic [DIV_W-1:0] slow_div;
  logic [DIV_W-1:0] rev_div;
  logic             scorer_won;

  assign press_l    = hit_l & ~hit_l_q;
  assign press_r    = hit_r & ~hit_r_q;
  assign tick       = (cnt == '0);
  assign hit_wrap   = (hit_cnt == HC_LAST);
  assign half_div   = cur_div >> 1;
  assign slow_div   = (half_div < MIN_V) ? MIN_V : half_div;
  // Period that takes effect from the reversal that is happening now.
  assign rev_div    = hit_wrap ? slow_div : cur_div;
  assign scorer_won = scorer ? (score_r == WIN_V) : (score_l == WIN_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      leds      <= '0;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      cnt       <= BASE_V - 1'b1;
      cur_div   <= BASE_V;
      hit_cnt   <= '0;
      flash_cnt <= '0;
      lockout_l <= 1'b0;
      lockout_r <= 1'b0;
      hit_l_q   <= 1'b0;
      hit_r_q   <= 1'b0;
      scorer    <= 1'b0;
    end else begin
      hit_l_q <= hit_l;
      hit_r_q <= hit_r;

      // Free-running prescaler; state entries and reversals below override it.
      if (tick) begin
        cnt <= (state == POINT) ? (BASE_V - 1'b1) : (cur_div - 1'b1);
      end else begin
        cnt <= cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          leds <= '0;
          if (serve_l || serve_r) begin
            cur_div   <= BASE_V;
            cnt       <= BASE_V - 1'b1;
            hit_cnt   <= '0;
            lockout_l <= 1'b0;
            lockout_r <= 1'b0;
            if (serve_l) begin
              leds  <= LEFT_END;
              state <= MOVE_R;
            end else begin
              leds  <= RIGHT_END;
              state <= MOVE_L;
            end
          end
        end

        MOVE_L: begin
          if (press_l && leds[WIDTH-1] && !lockout_l) begin
            // A valid hit beats a coincident tick; the ball waits at the end
            // for one full (possibly faster) period before moving off.
            state     <= MOVE_R;
            hit_cnt   <= hit_wrap ? '0 : hit_cnt + 1'b1;
            cur_div   <= rev_div;
            cnt       <= rev_div - 1'b1;
            lockout_l <= 1'b0;
            lockout_r <= 1'b0;
          end else begin
            if (press_l && !leds[WIDTH-1]) begin
              lockout_l <= 1'b1;
            end
            if (tick) begin
              if (!leds[WIDTH-1]) begin
                leds <= leds << 1;
              end else begin
                score_r   <= score_r + 1'b1;
                scorer    <= 1'b1;
                leds      <= ALL_ON;
                flash_cnt <= '0;
                cnt       <= BASE_V - 1'b1;
                state     <= POINT;
              end
            end
          end
        end

        MOVE_R: begin
          if (press_r && leds[0] && !lockout_r) begin
            state     <= MOVE_L;
            hit_cnt   <= hit_wrap ? '0 : hit_cnt + 1'b1;
            cur_div   <= rev_div;
            cnt       <= rev_div - 1'b1;
            lockout_l <= 1'b0;
            lockout_r <= 1'b0;
          end else begin
            if (press_r && !leds[0]) begin
              lockout_r <= 1'b1;
            end
            if (tick) begin
              if (!leds[0]) begin
                leds <= leds >> 1;
              end else begin
                score_l   <= score_l + 1'b1;
                scorer    <= 1'b0;
                leds      <= ALL_ON;
                flash_cnt <= '0;
                cnt       <= BASE_V - 1'b1;
                state     <= POINT;
              end
            end
          end
        end

        POINT: begin
          if (tick) begin
            if (flash_cnt == FL_LAST) begin
              cnt <= cur_div - 1'b1;
              if (scorer_won) begin
                leds      <= ALL_ON;
                game_over <= 1'b1;
                winner    <= scorer;
                state     <= OVER;
              end else begin
                leds  <= '0;
                state <= IDLE;
              end
            end else begin
              leds      <= ~leds;
              flash_cnt <= flash_cnt + 1'b1;
            end
          end
        end

        OVER: begin
          // Terminal until reset; serves and paddles have no effect.
          leds      <= ALL_ON;
          game_over <= 1'b1;
        end

        default: begin
          state <= IDLE;
          leds  <= '0;
        end
      endcase
    end
  end

endmodule
